// File: rtl/bp_io_host_responder.sv
// IO-side host responder: serves uncached BedRock commands from the IO link
// against a small host register map and returns one response per command.

package bp_io_host_pkg;

    localparam int paddr_width_gp   = 40;
    localparam int data_width_gp    = 512;
    localparam int payload_width_gp = 16;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        logic [2:0]                  size;
        logic [paddr_width_gp-1:0]   addr;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_cce_mem_header_s;

    typedef struct packed {
        logic [data_width_gp-1:0]   data;
        bp_bedrock_cce_mem_header_s header;
    } bp_bedrock_cce_mem_msg_s;

    localparam int msg_width_gp = $bits(bp_bedrock_cce_mem_msg_s);

endpackage

module bp_io_host_responder
    import bp_io_host_pkg::*;
#(
    parameter int          num_finish_p     = 4,
    parameter logic [19:0] putchar_offset_p = 20'h0_1000,
    parameter logic [19:0] finish_offset_p  = 20'h0_2000,
    parameter logic [19:0] scratch_offset_p = 20'h0_3000,
    parameter logic [19:0] cycle_offset_p   = 20'h0_4000
)(
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic [msg_width_gp-1:0] io_cmd_i,
    input  logic                    io_cmd_v_i,
    output logic                    io_cmd_ready_o,

    output logic [msg_width_gp-1:0] io_resp_o,
    output logic                    io_resp_v_o,
    input  logic                    io_resp_yumi_i,

    output logic [7:0]              putchar_data_o,
    output logic                    putchar_v_o,
    output logic [num_finish_p-1:0] finish_o,
    output logic                    all_finished_o,
    output logic                    fail_o,
    output logic                    decode_err_o
);

    localparam int fin_idx_w_lp = (num_finish_p > 1) ? $clog2(num_finish_p) : 1;

    bp_bedrock_cce_mem_msg_s cmd_cast;
    bp_bedrock_cce_mem_msg_s resp_d;
    bp_bedrock_cce_mem_msg_s fifo_r [2];

    logic [1:0]  count_r;
    logic        wptr_r;
    logic        rptr_r;
    logic        accept;
    logic        deq;

    logic [63:0] scratch_r;
    logic [63:0] cycle_r;
    logic [num_finish_p-1:0] finish_r;
    logic        fail_r;
    logic        decode_err_r;
    logic [7:0]  putchar_data_r;
    logic        putchar_v_r;

    logic [19:0] offset;
    logic [19:0] fin_delta;
    logic [fin_idx_w_lp-1:0] fin_idx;
    logic        is_rd;
    logic        is_wr;
    logic        hit_putchar;
    logic        hit_scratch;
    logic        hit_cycle;
    logic        fin_hit;
    logic        mapped;
    logic [63:0] size_mask;
    logic [63:0] wdata;
    logic [63:0] rd_raw;
    logic [63:0] rd_data;

    logic unused_bits;
    assign unused_bits = ^{cmd_cast.data[data_width_gp-1:64],
                           cmd_cast.header.addr[paddr_width_gp-1:20]};

    assign cmd_cast = io_cmd_i;

    // Ready is withheld during reset and whenever both entries are occupied
    assign io_cmd_ready_o = ~reset_i & (count_r != 2'd2);
    assign accept         = io_cmd_v_i & io_cmd_ready_o;
    assign io_resp_v_o    = (count_r != 2'd0);
    assign deq            = io_resp_yumi_i & io_resp_v_o;
    assign io_resp_o      = fifo_r[rptr_r];

    assign putchar_data_o = putchar_data_r;
    assign putchar_v_o    = putchar_v_r;
    assign finish_o       = finish_r;
    assign all_finished_o = &finish_r;
    assign fail_o         = fail_r;
    assign decode_err_o   = decode_err_r;

    // Address decode of the incoming command against the host register map
    always_comb begin
        offset      = cmd_cast.header.addr[19:0];
        is_rd       = (cmd_cast.header.msg_type == e_bedrock_mem_uc_rd);
        is_wr       = (cmd_cast.header.msg_type == e_bedrock_mem_uc_wr);
        fin_delta   = offset - finish_offset_p;
        fin_idx     = fin_delta[3 +: fin_idx_w_lp];
        hit_putchar = (offset == putchar_offset_p);
        hit_scratch = (offset == scratch_offset_p);
        hit_cycle   = (offset == cycle_offset_p);
        fin_hit     = (offset >= finish_offset_p)
                    && (fin_delta[2:0] == 3'b000)
                    && (fin_delta[19:3] < 17'(num_finish_p));
        mapped      = (is_rd | is_wr)
                    & (hit_putchar | hit_scratch | hit_cycle | fin_hit);
    end

    // Byte mask for 1/2/4/8-byte accesses; larger sizes clamp to 8 bytes
    always_comb begin
        unique case (cmd_cast.header.size)
            3'd0:    size_mask = 64'h0000_0000_0000_00FF;
            3'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            3'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        wdata = cmd_cast.data[63:0] & size_mask;
    end

    // Read mux and response assembly; the header echoes the command
    always_comb begin
        rd_raw = '0;
        unique case (1'b1)
            hit_scratch: rd_raw = scratch_r;
            hit_cycle:   rd_raw = cycle_r;
            fin_hit:     rd_raw = {63'b0, finish_r[fin_idx]};
            default:     rd_raw = '0;
        endcase
        rd_data = (is_rd & mapped) ? (rd_raw & size_mask) : 64'b0;
        resp_d             = '0;
        resp_d.header      = cmd_cast.header;
        resp_d.data[63:0]  = rd_data;
    end

    // Response storage; entries carry no reset since occupancy gates them
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_r[wptr_r] <= resp_d;
        end
    end

    // Occupancy and pointers of the 2-entry response buffer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= 2'd0;
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
        end else begin
            if (accept) begin
                wptr_r <= ~wptr_r;
            end
            if (deq) begin
                rptr_r <= ~rptr_r;
            end
            count_r <= count_r + {1'b0, accept} - {1'b0, deq};
        end
    end

    // Free-running 64-bit cycle counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_r <= '0;
        end else begin
            cycle_r <= cycle_r + 64'd1;
        end
    end

    // Register side effects applied in the accept cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scratch_r      <= '0;
            finish_r       <= '0;
            fail_r         <= 1'b0;
            decode_err_r   <= 1'b0;
            putchar_data_r <= '0;
            putchar_v_r    <= 1'b0;
        end else begin
            putchar_v_r <= accept & is_wr & hit_putchar;
            if (accept & is_wr & hit_putchar) begin
                putchar_data_r <= wdata[7:0];
            end
            if (accept & is_wr & hit_scratch) begin
                scratch_r <= (scratch_r & ~size_mask) | wdata;
            end
            if (accept & is_wr & fin_hit) begin
                finish_r[fin_idx] <= 1'b1;
                fail_r            <= fail_r | wdata[0];
            end
            if (accept & ~mapped) begin
                decode_err_r <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (reset_i)
        io_resp_yumi_i |-> io_resp_v_o);

    cmd_known_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i)
        io_cmd_v_i |-> !$isunknown(io_cmd_i));
`endif

endmodule

// File: tb/tb_bp_io_host_responder.sv
// Directed bench for bp_io_host_responder: register map, size masking,
// response buffering and reset behaviour.

module tb_bp_io_host_responder;
    import bp_io_host_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic [msg_width_gp-1:0] io_cmd_i;
    logic                    io_cmd_v_i;
    logic                    io_cmd_ready_o;
    logic [msg_width_gp-1:0] io_resp_o;
    logic                    io_resp_v_o;
    logic                    io_resp_yumi_i;
    logic [7:0]              putchar_data_o;
    logic                    putchar_v_o;
    logic [3:0]              finish_o;
    logic                    all_finished_o;
    logic                    fail_o;
    logic                    decode_err_o;

    bp_bedrock_cce_mem_msg_s resp_s;
    assign resp_s = io_resp_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    bp_io_host_responder dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .io_cmd_i       (io_cmd_i),
        .io_cmd_v_i     (io_cmd_v_i),
        .io_cmd_ready_o (io_cmd_ready_o),
        .io_resp_o      (io_resp_o),
        .io_resp_v_o    (io_resp_v_o),
        .io_resp_yumi_i (io_resp_yumi_i),
        .putchar_data_o (putchar_data_o),
        .putchar_v_o    (putchar_v_o),
        .finish_o       (finish_o),
        .all_finished_o (all_finished_o),
        .fail_o         (fail_o),
        .decode_err_o   (decode_err_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic bp_bedrock_cce_mem_msg_s mk(
        input bp_bedrock_mem_type_e t,
        input logic [39:0] a,
        input logic [2:0]  s,
        input logic [63:0] d,
        input logic [15:0] p);
        mk                 = '0;
        mk.header.msg_type = t;
        mk.header.addr     = a;
        mk.header.size     = s;
        mk.header.payload  = p;
        mk.data[63:0]      = d;
    endfunction

    task automatic issue(input bp_bedrock_cce_mem_msg_s m);
        io_cmd_i   = m;
        io_cmd_v_i = 1'b1;
        tick;
        io_cmd_v_i = 1'b0;
    endtask

    task automatic pop;
        if (io_resp_v_o) io_resp_yumi_i = 1'b1;
        tick;
        io_resp_yumi_i = 1'b0;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        tick;
        tick;
        checks++;
        if (io_cmd_ready_o !== 1'b0) begin
            failures++; $display("FAIL rst_ready got=%0b exp=0", io_cmd_ready_o);
        end
        checks++;
        if (io_resp_v_o !== 1'b0) begin
            failures++; $display("FAIL rst_resp_v got=%0b exp=0", io_resp_v_o);
        end
        checks++;
        if ({finish_o, all_finished_o, fail_o, decode_err_o, putchar_v_o} !== 8'b0) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=0",
                     {finish_o, all_finished_o, fail_o, decode_err_o, putchar_v_o});
        end
        checks++;
        if (putchar_data_o !== 8'h00) begin
            failures++; $display("FAIL rst_putchar_data got=%h exp=00", putchar_data_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (io_cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_ready_after got=%0b exp=1", io_cmd_ready_o);
        end
    endtask

    task automatic test_putchar;
        bp_bedrock_cce_mem_msg_s m;
        m = mk(e_bedrock_mem_uc_wr, 40'h1000, 3'd0, 64'h41, 16'hA001);
        io_cmd_i   = m;
        io_cmd_v_i = 1'b1;
        #1;
        checks++;
        if (io_resp_v_o !== 1'b0) begin
            failures++; $display("FAIL put_resp_v_early got=%0b exp=0", io_resp_v_o);
        end
        tick;
        io_cmd_v_i = 1'b0;
        checks++;
        if (putchar_v_o !== 1'b1 || putchar_data_o !== 8'h41) begin
            failures++;
            $display("FAIL put_pulse got=%0b/%h exp=1/41", putchar_v_o, putchar_data_o);
        end
        checks++;
        if (io_resp_v_o !== 1'b1) begin
            failures++; $display("FAIL put_resp_v got=%0b exp=1", io_resp_v_o);
        end
        checks++;
        if (resp_s.header !== m.header || resp_s.data !== 512'h0) begin
            failures++;
            $display("FAIL put_resp got=%h/%h exp=%h/0",
                     resp_s.header, resp_s.data[63:0], m.header);
        end
        tick;
        checks++;
        if (putchar_v_o !== 1'b0) begin
            failures++; $display("FAIL put_pulse_len got=%0b exp=0", putchar_v_o);
        end
        pop;
        checks++;
        if (io_resp_v_o !== 1'b0) begin
            failures++; $display("FAIL put_drain got=%0b exp=0", io_resp_v_o);
        end
    endtask

    task automatic test_scratch;
        issue(mk(e_bedrock_mem_uc_wr, 40'h3000, 3'd3, 64'hDEAD_BEEF_0123_4567, 16'h1));
        pop;
        issue(mk(e_bedrock_mem_uc_rd, 40'h3000, 3'd3, 64'h0, 16'h2));
        checks++;
        if (resp_s.data !== {448'h0, 64'hDEAD_BEEF_0123_4567}) begin
            failures++; $display("FAIL scr_rd8 got=%h exp=deadbeef01234567", resp_s.data);
        end
        pop;
        issue(mk(e_bedrock_mem_uc_rd, 40'h3000, 3'd1, 64'h0, 16'h3));
        checks++;
        if (resp_s.data !== {496'h0, 16'h4567}) begin
            failures++; $display("FAIL scr_rd2 got=%h exp=4567", resp_s.data);
        end
        pop;
        issue(mk(e_bedrock_mem_uc_wr, 40'h3000, 3'd0, 64'hFFFF, 16'h4));
        pop;
        issue(mk(e_bedrock_mem_uc_rd, 40'h3000, 3'd3, 64'h0, 16'h5));
        checks++;
        if (resp_s.data !== {448'h0, 64'hDEAD_BEEF_0123_45FF}) begin
            failures++; $display("FAIL scr_byte_wr got=%h exp=deadbeef012345ff", resp_s.data);
        end
        pop;
    endtask

    task automatic test_back_to_back;
        bp_bedrock_cce_mem_msg_s a, b, c;
        a = mk(e_bedrock_mem_uc_wr, 40'h3000, 3'd3, 64'h1111, 16'hB00A);
        b = mk(e_bedrock_mem_uc_rd, 40'h3000, 3'd3, 64'h0, 16'hB00B);
        c = mk(e_bedrock_mem_uc_rd, 40'h1000, 3'd3, 64'h0, 16'hB00C);
        io_cmd_v_i = 1'b1;
        io_cmd_i   = a;
        tick;
        io_cmd_i   = b;
        tick;
        io_cmd_i   = c;
        checks++;
        if (io_cmd_ready_o !== 1'b0) begin
            failures++; $display("FAIL bp_full_ready got=%0b exp=0", io_cmd_ready_o);
        end
        tick;
        checks++;
        if (io_cmd_ready_o !== 1'b0 || resp_s.header !== a.header) begin
            failures++;
            $display("FAIL bp_stall got=%0b/%h exp=0/%h",
                     io_cmd_ready_o, resp_s.header, a.header);
        end
        io_resp_yumi_i = 1'b1;
        tick;
        io_resp_yumi_i = 1'b0;
        checks++;
        if (io_cmd_ready_o !== 1'b1 || resp_s.header !== b.header) begin
            failures++;
            $display("FAIL bp_after_deq got=%0b/%h exp=1/%h",
                     io_cmd_ready_o, resp_s.header, b.header);
        end
        checks++;
        if (resp_s.data !== {448'h0, 64'h1111}) begin
            failures++; $display("FAIL bp_b_data got=%h exp=1111", resp_s.data);
        end
        tick;
        io_cmd_v_i = 1'b0;
        pop;
        checks++;
        if (io_resp_v_o !== 1'b1 || resp_s.header !== c.header || resp_s.data !== 512'h0) begin
            failures++;
            $display("FAIL bp_c got=%0b/%h/%h exp=1/%h/0",
                     io_resp_v_o, resp_s.header, resp_s.data[63:0], c.header);
        end
        pop;
        checks++;
        if (io_resp_v_o !== 1'b0) begin
            failures++; $display("FAIL bp_drain got=%0b exp=0", io_resp_v_o);
        end
    endtask

    task automatic test_cycle;
        do_reset;
        issue(mk(e_bedrock_mem_uc_wr, 40'h4000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 16'hC1));
        checks++;
        if (decode_err_o !== 1'b0) begin
            failures++; $display("FAIL cyc_wr_err got=%0b exp=0", decode_err_o);
        end
        pop;
        issue(mk(e_bedrock_mem_uc_rd, 40'h4000, 3'd3, 64'h0, 16'hC2));
        checks++;
        if (resp_s.data !== {448'h0, 64'd2}) begin
            failures++; $display("FAIL cyc_rd got=%h exp=2", resp_s.data);
        end
        pop;
    endtask

    task automatic test_unmapped;
        bp_bedrock_cce_mem_msg_s m;
        do_reset;
        m = mk(e_bedrock_mem_uc_rd, 40'h5000, 3'd3, 64'h0, 16'hD1);
        issue(m);
        checks++;
        if (io_resp_v_o !== 1'b1 || resp_s.header !== m.header || resp_s.data !== 512'h0) begin
            failures++;
            $display("FAIL unm_rd_resp got=%0b/%h/%h exp=1/%h/0",
                     io_resp_v_o, resp_s.header, resp_s.data[63:0], m.header);
        end
        checks++;
        if (decode_err_o !== 1'b1) begin
            failures++; $display("FAIL unm_rd_err got=%0b exp=1", decode_err_o);
        end
        pop;
        do_reset;
        issue(mk(e_bedrock_mem_uc_wr, 40'h2020, 3'd3, 64'h0, 16'hD2));
        checks++;
        if (decode_err_o !== 1'b1 || finish_o !== 4'b0000) begin
            failures++;
            $display("FAIL unm_fin4 got=%0b/%b exp=1/0000", decode_err_o, finish_o);
        end
        pop;
        do_reset;
        issue(mk(e_bedrock_mem_uc_wr, 40'h3000, 3'd3, 64'h55, 16'hD3));
        checks++;
        if (decode_err_o !== 1'b0) begin
            failures++; $display("FAIL unm_clean got=%0b exp=0", decode_err_o);
        end
        pop;
        m = mk(e_bedrock_mem_rd, 40'h3000, 3'd3, 64'h0, 16'hD4);
        issue(m);
        checks++;
        if (io_resp_v_o !== 1'b1 || resp_s.header !== m.header || resp_s.data !== 512'h0) begin
            failures++;
            $display("FAIL unsup_resp got=%0b/%h/%h exp=1/%h/0",
                     io_resp_v_o, resp_s.header, resp_s.data[63:0], m.header);
        end
        checks++;
        if (decode_err_o !== 1'b1) begin
            failures++; $display("FAIL unsup_err got=%0b exp=1", decode_err_o);
        end
        pop;
    endtask

    task automatic test_finish;
        logic [3:0] exp_fin;
        do_reset;
        exp_fin = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            issue(mk(e_bedrock_mem_uc_wr, 40'h2000 + 40'(8 * i), 3'd3, 64'h0, 16'(i)));
            exp_fin[i] = 1'b1;
            checks++;
            if (finish_o !== exp_fin || all_finished_o !== (i == 3)) begin
                failures++;
                $display("FAIL fin_wr%0d got=%b/%0b exp=%b/%0b",
                         i, finish_o, all_finished_o, exp_fin, (i == 3));
            end
            pop;
        end
        checks++;
        if (fail_o !== 1'b0 || decode_err_o !== 1'b0) begin
            failures++;
            $display("FAIL fin_pass got=%0b/%0b exp=0/0", fail_o, decode_err_o);
        end
        issue(mk(e_bedrock_mem_uc_wr, 40'h2010, 3'd0, 64'h1, 16'hE1));
        checks++;
        if (fail_o !== 1'b1) begin
            failures++; $display("FAIL fin_fail got=%0b exp=1", fail_o);
        end
        pop;
        issue(mk(e_bedrock_mem_uc_rd, 40'h2008, 3'd3, 64'h0, 16'hE2));
        checks++;
        if (resp_s.data !== {448'h0, 64'h1}) begin
            failures++; $display("FAIL fin_rd got=%h exp=1", resp_s.data);
        end
        pop;
    endtask

    task automatic test_reset_mid;
        issue(mk(e_bedrock_mem_uc_wr, 40'h3000, 3'd3, 64'h77, 16'hF1));
        issue(mk(e_bedrock_mem_uc_wr, 40'h1000, 3'd0, 64'h42, 16'hF2));
        checks++;
        if (io_resp_v_o !== 1'b1 || io_cmd_ready_o !== 1'b0 || putchar_data_o !== 8'h42) begin
            failures++;
            $display("FAIL mid_pre got=%0b/%0b/%h exp=1/0/42",
                     io_resp_v_o, io_cmd_ready_o, putchar_data_o);
        end
        reset_i = 1'b1;
        tick;
        checks++;
        if (io_resp_v_o !== 1'b0 || io_cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_hs got=%0b/%0b exp=0/0", io_resp_v_o, io_cmd_ready_o);
        end
        checks++;
        if ({finish_o, all_finished_o, fail_o, decode_err_o, putchar_v_o, putchar_data_o}
            !== 16'h0) begin
            failures++;
            $display("FAIL mid_rst_regs got=%b/%0b/%0b/%0b/%h exp=0",
                     finish_o, all_finished_o, fail_o, decode_err_o, putchar_data_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (io_cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL mid_ready got=%0b exp=1", io_cmd_ready_o);
        end
        issue(mk(e_bedrock_mem_uc_rd, 40'h4000, 3'd3, 64'h0, 16'hF3));
        checks++;
        if (resp_s.data !== 512'h0) begin
            failures++; $display("FAIL mid_cycle got=%h exp=0", resp_s.data);
        end
        pop;
        issue(mk(e_bedrock_mem_uc_rd, 40'h3000, 3'd3, 64'h0, 16'hF4));
        checks++;
        if (resp_s.data !== 512'h0) begin
            failures++; $display("FAIL mid_scratch got=%h exp=0", resp_s.data);
        end
        pop;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i        = 1'b1;
        io_cmd_v_i     = 1'b0;
        io_resp_yumi_i = 1'b0;
        io_cmd_i       = '0;
        test_reset;
        test_putchar;
        test_scratch;
        test_back_to_back;
        test_cycle;
        test_unmapped;
        test_finish;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
